// File: rtl/call_ret_stack_if.sv
// CALL/RET stack port bundle: push/pop/flush requests in, stack status out.
interface call_ret_stack_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic              pop;
  logic [ADDR_W-1:0] top_addr;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, push, push_addr, pop,
    input  top_addr, empty, full, count, overflow, underflow
  );

  modport slave (
    input  flush, push, push_addr, pop,
    output top_addr, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/call_ret_stack.sv
// Return-address stack: circular buffer, overflow drops oldest, sticky
// overflow/underflow flags, zero-latency top read.
module call_ret_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
) (
  input logic             clk,
  input logic             rst,
  call_ret_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     tptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              is_empty;
  logic              is_full;

  assign tptr     = wptr - PW'(1);
  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      count <= '0;
    end else if (bus.push && bus.pop && !is_empty) begin
      // Simultaneous CALL/RET: replace top in place, never flags.
      mem[tptr] <= bus.push_addr;
    end else if (bus.push) begin
      mem[wptr] <= bus.push_addr;
      wptr      <= wptr + PW'(1);
      if (is_full) overflow <= 1'b1;
      else         count    <= count + CW'(1);
      if (bus.pop) underflow <= 1'b1;
    end else if (bus.pop) begin
      if (is_empty) begin
        underflow <= 1'b1;
      end else begin
        wptr  <= tptr;
        count <= count - CW'(1);
      end
    end
  end

  assign bus.top_addr  = is_empty ? '0 : mem[tptr];
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_call_ret_stack.sv
// Random + directed bench for call_ret_stack against a queue-based model.
module tb_call_ret_stack;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  call_ret_stack_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  call_ret_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: queue of live entries, oldest at front, top at back.
  logic [ADDR_W-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else if (bus.flush) begin
      q.delete();
    end else if (bus.push && bus.pop) begin
      if (q.size() > 0) q[q.size()-1] = bus.push_addr;
      else begin q.push_back(bus.push_addr); m_udf = 1'b1; end
    end else if (bus.push) begin
      if (q.size() == DEPTH) begin void'(q.pop_front()); m_ovf = 1'b1; end
      q.push_back(bus.push_addr);
    end else if (bus.pop) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_udf = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_top",   int'(bus.top_addr), (q.size() > 0) ? int'(q[q.size()-1]) : 0);
      chk("model_count", int'(bus.count), q.size());
      chk("model_empty", int'(bus.empty), int'(q.size() == 0));
      chk("model_full",  int'(bus.full), int'(q.size() == DEPTH));
      chk("model_ovf",   int'(bus.overflow), int'(m_ovf));
      chk("model_udf",   int'(bus.underflow), int'(m_udf));
    end
  end

  // Apply one cycle of inputs, return at the following negedge.
  task automatic step(input bit r, input bit f, input bit pu, input bit po,
                      input logic [ADDR_W-1:0] a);
    rst = r; bus.flush = f; bus.push = pu; bus.pop = po; bus.push_addr = a;
    @(negedge clk);
  endtask

  task automatic do_push(input logic [ADDR_W-1:0] a); step(0, 0, 1, 0, a); endtask
  task automatic do_pop();                            step(0, 0, 0, 1, '0); endtask
  task automatic do_rst();                            step(1, 0, 0, 0, '0); endtask

  initial begin
    bus.flush = 0; bus.push = 0; bus.pop = 0; bus.push_addr = '0;
    @(negedge clk);
    do_rst();
    chk_en = 1'b1;
    chk("rst_top", int'(bus.top_addr), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_count", int'(bus.count), 0);

    // basic LIFO
    do_push(16'h0010); do_push(16'h0020); do_push(16'h0030);
    chk("t1_top", int'(bus.top_addr), 'h30);
    chk("t1_count", int'(bus.count), 3);
    chk("t1_pop0", int'(bus.top_addr), 'h30); do_pop();
    chk("t1_pop1", int'(bus.top_addr), 'h20); do_pop();
    chk("t1_pop2", int'(bus.top_addr), 'h10); do_pop();
    chk("t1_empty", int'(bus.empty), 1);
    chk("t1_top0", int'(bus.top_addr), 0);

    // overflow drops the oldest
    for (int i = 0; i < 9; i++) do_push(ADDR_W'(16'h0100 + i));
    chk("t2_full", int'(bus.full), 1);
    chk("t2_count", int'(bus.count), 8);
    chk("t2_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop", int'(bus.top_addr), 'h108 - i);
      do_pop();
    end
    chk("t2_empty", int'(bus.empty), 1);

    // underflow
    do_pop();
    chk("t3_udf", int'(bus.underflow), 1);
    chk("t3_count", int'(bus.count), 0);
    do_push(16'h0042);
    chk("t3_top", int'(bus.top_addr), 'h42);
    chk("t3_udf_sticky", int'(bus.underflow), 1);

    // push+pop replaces top
    do_rst();
    do_push(16'h0010); do_push(16'h0020);
    step(0, 0, 1, 1, 16'h0055);
    chk("t4_count", int'(bus.count), 2);
    chk("t4_top", int'(bus.top_addr), 'h55);
    do_pop();
    chk("t4_next", int'(bus.top_addr), 'h10);
    do_pop();
    step(0, 0, 1, 1, 16'h0077);
    chk("t4_e_count", int'(bus.count), 1);
    chk("t4_e_top", int'(bus.top_addr), 'h77);
    chk("t4_e_udf", int'(bus.underflow), 1);

    // flush beats push, keeps flags
    do_rst();
    for (int i = 0; i < 9; i++) do_push(ADDR_W'(i + 1));
    do_pop(); do_pop(); do_pop();
    chk("t5_count5", int'(bus.count), 5);
    step(0, 1, 1, 0, 16'h0999);
    chk("t5_count", int'(bus.count), 0);
    chk("t5_empty", int'(bus.empty), 1);
    chk("t5_ovf", int'(bus.overflow), 1);

    // reset beats push
    do_push(16'h0abc); do_pop(); do_pop();
    step(1, 0, 1, 0, 16'h0def);
    chk("t6_count", int'(bus.count), 0);
    chk("t6_top", int'(bus.top_addr), 0);
    chk("t6_ovf", int'(bus.overflow), 0);
    chk("t6_udf", int'(bus.underflow), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 45),
           ADDR_W'($urandom));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
